// File: rtl/puc_pkg.sv
// Shared loader constants and the loader FSM state encoding.
// No logic, so no latency.
// No handshake of its own; used by program_loader.
package puc_pkg;

  localparam int COUNTER_WIDTH     = 8;
  localparam int INSTRUCTION_WIDTH = 12;
  localparam int OPCODE_WIDTH      = 4;
  localparam int VALUE_WIDTH       = 8;
  localparam int MEM_DEPTH         = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Loads a framed byte stream (LEN, N x {HI,LO}, CHK) into instruction memory and
// releases the CPU hold after the XOR checksum matches.
// A write strobe appears 1 cycle after the LO byte is accepted; flags appear 1 cycle after CHK.
// rxReady is registered: high only while a frame is being received, so bytes offered outside a load stall.
module program_loader #(
  parameter int COUNTER_WIDTH     = puc_pkg::COUNTER_WIDTH,
  parameter int INSTRUCTION_WIDTH = puc_pkg::INSTRUCTION_WIDTH,
  parameter int MEM_DEPTH         = puc_pkg::MEM_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   rxData,
  input  logic                         rxValid,
  output logic                         rxReady,
  output logic                         memWriteEnable,
  output logic [COUNTER_WIDTH-1:0]     memAddress,
  output logic [INSTRUCTION_WIDTH-1:0] memWriteData,
  output logic                         cpuHold,
  output logic                         loadDone,
  output logic                         loadError,
  output logic [COUNTER_WIDTH-1:0]     loadedCount
);

  import puc_pkg::*;

  loader_state_t             state;
  logic [COUNTER_WIDTH-1:0]  word_total;
  logic [OPCODE_WIDTH-1:0]   opcode_q;
  logic [7:0]                checksum;
  logic                      accept;

  // A byte moves only when both sides agree at the clock edge.
  assign accept = rxValid && rxReady;

  // Loader FSM: frame parsing, memory write strobe, checksum and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cpuHold        <= 1'b1;
      rxReady        <= 1'b0;
      memWriteEnable <= 1'b0;
      memAddress     <= '0;
      memWriteData   <= '0;
      loadDone       <= 1'b0;
      loadError      <= 1'b0;
      loadedCount    <= '0;
      checksum       <= '0;
      word_total     <= '0;
      opcode_q       <= '0;
    end else begin
      // The strobe is a single-cycle pulse; only the LO branch raises it.
      memWriteEnable <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state       <= LEN;
            rxReady     <= 1'b1;
            cpuHold     <= 1'b1;
            loadDone    <= 1'b0;
            loadError   <= 1'b0;
            loadedCount <= '0;
            checksum    <= '0;
          end
        end
        LEN: begin
          if (accept) begin
            checksum <= checksum ^ rxData;
            if (rxData == 8'h00 || int'(rxData) > MEM_DEPTH) begin
              state     <= ERROR;
              rxReady   <= 1'b0;
              loadError <= 1'b1;
            end else begin
              word_total <= COUNTER_WIDTH'(rxData);
              state      <= HI;
            end
          end
        end
        HI: begin
          if (accept) begin
            checksum <= checksum ^ rxData;
            // Upper nibble is reserved; a non-zero value means the stream is out of step.
            if (rxData[7:OPCODE_WIDTH] != '0) begin
              state     <= ERROR;
              rxReady   <= 1'b0;
              loadError <= 1'b1;
            end else begin
              opcode_q <= rxData[OPCODE_WIDTH-1:0];
              state    <= LO;
            end
          end
        end
        LO: begin
          if (accept) begin
            checksum       <= checksum ^ rxData;
            memWriteEnable <= 1'b1;
            memAddress     <= loadedCount;
            memWriteData   <= INSTRUCTION_WIDTH'({opcode_q, rxData});
            loadedCount    <= loadedCount + COUNTER_WIDTH'(1);
            if (loadedCount == word_total - COUNTER_WIDTH'(1)) begin
              state <= CHK;
            end else begin
              state <= HI;
            end
          end
        end
        CHK: begin
          if (accept) begin
            checksum <= checksum ^ rxData;
            rxReady  <= 1'b0;
            if (rxData == checksum) begin
              state    <= DONE;
              loadDone <= 1'b1;
              cpuHold  <= 1'b0;
            end else begin
              state     <= ERROR;
              loadError <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          rxReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Byte-stream loader that fills the CPU's instruction memory and holds the CPU in reset until a program has been loaded and verified. It receives a framed byte stream over a valid/ready handshake and writes one INSTRUCTION_WIDTH word per two payload bytes to the memory write port addressed by the program counter space. It releases cpuHold only after a correct XOR checksum.

Parameters:
COUNTER_WIDTH, 8, width of memAddress and loadedCount; matches the CPU program counter
INSTRUCTION_WIDTH, 12, instruction word width: opcode [11:8], value [7:0]
MEM_DEPTH, 16, number of writable instruction words; lengths above this are rejected

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high
start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR
rxData  input  8  stream byte
rxValid  input  1  rxData valid
rxReady  output  1  loader can accept a byte; transfer happens when rxValid && rxReady at the clock edge
memWriteEnable  output  1  one-cycle write strobe
memAddress  output  COUNTER_WIDTH  write address
memWriteData  output  INSTRUCTION_WIDTH  {opcode, value}
cpuHold  output  1  high holds the CPU in reset/stall
loadDone  output  1  program loaded and checksum matched
loadError  output  1  framing, length or checksum failure
loadedCount  output  COUNTER_WIDTH  words written in the current load

Behaviour:
- Reset (asynchronous, active-high) forces the following, all registered outputs:
  - state=IDLE, cpuHold=1, rxReady=0, memWriteEnable=0, memAddress=0, memWriteData=0, loadDone=0, loadError=0, loadedCount=0, checksum=0.
- Frame: LEN byte N; then N pairs of HI byte (bits [7:4] must be 0, bits [3:0]=opcode) and LO byte (value); then CHK byte.
- CHK must equal the XOR of LEN and all payload bytes.
- States:
  - IDLE: start -> LEN; clears loadDone, loadError, loadedCount and checksum.
  - LEN: on accepted byte, N==0 or N>MEM_DEPTH -> ERROR; otherwise latch N and go to HI.
  - HI: on accepted byte, bits [7:4]!=0 -> ERROR; otherwise latch opcode and go to LO.
  - LO: on accepted byte, register memWriteEnable=1, memAddress=loadedCount, memWriteData={opcode,rxData}.
    - The write strobe is visible the cycle after acceptance, for exactly 1 cycle.
    - loadedCount increments in that same cycle.
    - If this was word N -> CHK, else -> HI.
  - CHK: on accepted byte, match -> DONE, otherwise -> ERROR.
  - DONE: loadDone=1, cpuHold=0 from the cycle after CHK acceptance.
  - ERROR: loadError=1, cpuHold stays 1.
  - DONE/ERROR + start -> LEN with flags cleared. cpuHold returns to 1 on the cycle after start.
- rxReady=1 exactly in LEN, HI, LO and CHK. Bytes offered in IDLE, DONE or ERROR are not accepted and have no effect.
- rxValid may drop at any time; a gap stalls the FSM with no state change. Back-to-back bytes are accepted at 1 per cycle.
- The checksum XORs every accepted byte from LEN onward, including bytes that cause ERROR.
- start while in LEN, HI, LO or CHK is ignored.
- Reset mid-load returns to the reset values immediately. Words already written remain in memory; the next load overwrites from address 0.
- memAddress and memWriteData hold their last value when memWriteEnable=0.

Decomposition:
- Shared package puc_pkg holds:
  - COUNTER_WIDTH, INSTRUCTION_WIDTH, OPCODE_WIDTH=4, VALUE_WIDTH=8.
  - loader_state_t enum {IDLE, LEN, HI, LO, CHK, DONE, ERROR}.
- Single module; no sub-module. The checksum is one XOR register inside the FSM.

Test Plan:
1. Basic load:
   - Stimulus: start, then bytes 02,01,23,0A,45,6F back-to-back.
   - Response: writes addr0=0x123 and addr1=0xA45, each a 1-cycle strobe; loadedCount=2; loadDone=1 and cpuHold=0 the cycle after 6F.
2. Bad checksum: same frame with CHK=00 -> both writes occur, then loadError=1, loadDone=0, cpuHold=1; rxReady=0 afterwards.
3. Framing error: start, then bytes 01,31 -> ERROR after HI; no memWriteEnable pulse; loadedCount=0.
4. Length errors:
   - start, then LEN=00 -> ERROR.
   - start, then LEN=11 (17 > MEM_DEPTH 16) -> ERROR.
   - start, then LEN=10 with 16 valid words and correct CHK -> DONE; last write at addr 15.
5. Handshake:
   - Bytes driven in IDLE are ignored.
   - Scenario 1 repeated with random rxValid gaps gives identical writes.
   - start pulses mid-frame change nothing.
6. Reset mid-load: assert reset after the first write of scenario 1 -> all outputs return to reset values at once; a new start plus the full frame gives a correct DONE with writes from addr0.
